// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative MUL/DIVU, overflow detect,
// and the EX/MEM pipeline registers.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] id_pc,
    input  logic        id_en_,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_in_0,
    input  logic [31:0] id_alu_in_1,
    input  logic        id_br_flag,
    input  logic [1:0]  id_mem_op,
    input  logic [31:0] id_mem_wr_data,
    input  logic [1:0]  id_ctrl_op,
    input  logic [4:0]  id_dst_addr,
    input  logic        id_gpr_we_,
    input  logic [2:0]  id_exp_code,
    output logic        ex_busy,
    output logic [31:0] ex_fwd_data,
    output logic [29:0] ex_pc,
    output logic        ex_en_,
    output logic        ex_br_flag,
    output logic [1:0]  ex_mem_op,
    output logic [31:0] ex_mem_wr_data,
    output logic [1:0]  ex_ctrl_op,
    output logic [4:0]  ex_dst_addr,
    output logic        ex_gpr_we_,
    output logic [2:0]  ex_exp_code,
    output logic [31:0] ex_out
);

    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_ADDS = 4'd4;
    localparam logic [3:0] OP_ADDU = 4'd5;
    localparam logic [3:0] OP_SUBS = 4'd6;
    localparam logic [3:0] OP_SUBU = 4'd7;
    localparam logic [3:0] OP_SHRL = 4'd8;
    localparam logic [3:0] OP_SHLL = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    localparam logic [2:0] EXP_OVF = 3'd3;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;

    logic [31:0] sum, diff, alu_res;
    logic        ovf_add, ovf_sub, ov_hit;
    logic        start, done, clr;
    logic [31:0] step_a, step_b, step_c;
    logic [32:0] rem_sh;
    logic [31:0] mc_res;

    assign sum  = id_alu_in_0 + id_alu_in_1;
    assign diff = id_alu_in_0 - id_alu_in_1;

    assign ovf_add = (id_alu_in_0[31] == id_alu_in_1[31])
                   && (sum[31] != id_alu_in_0[31]);
    assign ovf_sub = (id_alu_in_0[31] != id_alu_in_1[31])
                   && (diff[31] != id_alu_in_0[31]);

    always_comb begin
        alu_res = '0;
        unique case (id_alu_op)
            OP_AND:  alu_res = id_alu_in_0 & id_alu_in_1;
            OP_OR:   alu_res = id_alu_in_0 | id_alu_in_1;
            OP_XOR:  alu_res = id_alu_in_0 ^ id_alu_in_1;
            OP_ADDS: alu_res = sum;
            OP_ADDU: alu_res = sum;
            OP_SUBS: alu_res = diff;
            OP_SUBU: alu_res = diff;
            OP_SHRL: alu_res = id_alu_in_0 >> id_alu_in_1[4:0];
            OP_SHLL: alu_res = id_alu_in_0 << id_alu_in_1[4:0];
            default: alu_res = '0;
        endcase
    end

    assign ex_fwd_data = alu_res;

    assign ov_hit = !id_en_ && (id_exp_code == 3'd0)
                  && (((id_alu_op == OP_ADDS) && ovf_add)
                   || ((id_alu_op == OP_SUBS) && ovf_sub));

    assign start = !id_en_ && !flush
                 && ((id_alu_op == OP_MUL) || (id_alu_op == OP_DIVU));
    assign done  = (state_q == RUN) && (cnt_q == 5'd31);

    assign ex_busy = ((state_q == IDLE) && start)
                   || ((state_q == RUN) && (cnt_q != 5'd31) && !flush);

    // a: accumulator/remainder, b: multiplicand/divisor,
    // c: multiplier/quotient-dividend shift register
    assign rem_sh = {a_q, c_q[31]};

    always_comb begin
        step_a = a_q;
        step_b = b_q;
        step_c = c_q;
        if (div_q) begin
            if (rem_sh >= {1'b0, b_q}) begin
                step_a = rem_sh[31:0] - b_q;
                step_c = {c_q[30:0], 1'b1};
            end else begin
                step_a = rem_sh[31:0];
                step_c = {c_q[30:0], 1'b0};
            end
        end else begin
            step_a = a_q + (c_q[0] ? b_q : 32'd0);
            step_b = b_q << 1;
            step_c = c_q >> 1;
        end
    end

    assign mc_res = div_q ? step_c : step_a;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 5'd0;
                    div_d   = (id_alu_op == OP_DIVU);
                    a_d     = '0;
                    b_d     = div_d ? id_alu_in_1 : id_alu_in_0;
                    c_d     = div_d ? id_alu_in_0 : id_alu_in_1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q != 5'd31) begin
                    cnt_d = cnt_q + 5'd1;
                    a_d   = step_a;
                    b_d   = step_b;
                    c_d   = step_c;
                end else if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    // Bubble whenever the stage is cleared or busy and not stalled
    assign clr = reset || flush || (!stall && ex_busy);

    always_ff @(posedge clk) begin
        if (clr) begin
            ex_pc          <= '0;
            ex_en_         <= 1'b1;
            ex_br_flag     <= 1'b0;
            ex_mem_op      <= '0;
            ex_mem_wr_data <= '0;
            ex_ctrl_op     <= '0;
            ex_dst_addr    <= '0;
            ex_gpr_we_     <= 1'b1;
            ex_exp_code    <= '0;
            ex_out         <= '0;
        end else if (!stall) begin
            ex_pc          <= id_pc;
            ex_en_         <= id_en_;
            ex_br_flag     <= id_br_flag;
            ex_mem_op      <= ov_hit ? 2'd0 : id_mem_op;
            ex_mem_wr_data <= id_mem_wr_data;
            ex_ctrl_op     <= id_ctrl_op;
            ex_dst_addr    <= id_dst_addr;
            ex_gpr_we_     <= ov_hit ? 1'b1 : id_gpr_we_;
            ex_exp_code    <= ov_hit ? EXP_OVF : id_exp_code;
            ex_out         <= done ? mc_res : alu_res;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [29:0] id_pc;
    logic        id_en_;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0;
    logic [31:0] id_alu_in_1;
    logic        id_br_flag;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [1:0]  id_ctrl_op;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic [2:0]  id_exp_code;
    logic        ex_busy;
    logic [31:0] ex_fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en_;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;

    int n_vec;
    int n_err;

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .id_pc          (id_pc),
        .id_en_         (id_en_),
        .id_alu_op      (id_alu_op),
        .id_alu_in_0    (id_alu_in_0),
        .id_alu_in_1    (id_alu_in_1),
        .id_br_flag     (id_br_flag),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_ctrl_op     (id_ctrl_op),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .id_exp_code    (id_exp_code),
        .ex_busy        (ex_busy),
        .ex_fwd_data    (ex_fwd_data),
        .ex_pc          (ex_pc),
        .ex_en_         (ex_en_),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd1:       return a & b;
            4'd2:       return a | b;
            4'd3:       return a ^ b;
            4'd4, 4'd5: return a + b;
            4'd6, 4'd7: return a - b;
            4'd8:       return a >> (b % 32);
            4'd9:       return a << (b % 32);
            default:    return 32'd0;
        endcase
    endfunction

    function automatic bit ref_ov(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = (op == 4'd4) ? sa + sb : sa - sb;
        if (op != 4'd4 && op != 4'd6) return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] ref_mc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        if (op == 4'd10) return a * b;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic en_,
                         input logic [2:0] ec, input logic we_);
        id_alu_op      = op;
        id_alu_in_0    = a;
        id_alu_in_1    = b;
        id_en_         = en_;
        id_exp_code    = ec;
        id_gpr_we_     = we_;
        id_pc          = 30'($urandom);
        id_br_flag     = 1'($urandom);
        id_mem_op      = 2'($urandom);
        id_mem_wr_data = $urandom;
        id_ctrl_op     = 2'($urandom);
        id_dst_addr    = 5'($urandom);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, 32'(ex_pc), 32'd0);
        chk({tag, "_en"}, 32'(ex_en_), 32'd1);
        chk({tag, "_we"}, 32'(ex_gpr_we_), 32'd1);
        chk({tag, "_mop"}, 32'(ex_mem_op), 32'd0);
        chk({tag, "_exp"}, 32'(ex_exp_code), 32'd0);
        chk({tag, "_out"}, ex_out, 32'd0);
    endtask

    task automatic single(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic en_,
                          input logic [2:0] ec, input logic we_);
        logic [29:0] e_pc;
        logic [1:0]  e_mop;
        logic [4:0]  e_dst;
        bit          hit;
        drive(op, a, b, en_, ec, we_);
        e_pc  = id_pc;
        e_mop = id_mem_op;
        e_dst = id_dst_addr;
        hit   = !en_ && (ec == 3'd0) && ref_ov(op, a, b);
        #1;
        if (op != 4'd10 && op != 4'd11)
            chk("fwd", ex_fwd_data, ref_alu(op, a, b));
        chk("busy_single", 32'(ex_busy), 32'd0);
        @(posedge clk); #1;
        chk("out", ex_out, ref_alu(op, a, b));
        chk("exp", 32'(ex_exp_code), hit ? 32'd3 : 32'(ec));
        chk("we", 32'(ex_gpr_we_), hit ? 32'd1 : 32'(we_));
        chk("mop", 32'(ex_mem_op), hit ? 32'd0 : 32'(e_mop));
        chk("pc", 32'(ex_pc), 32'(e_pc));
        chk("en", 32'(ex_en_), 32'(en_));
        chk("dst", 32'(ex_dst_addr), 32'(e_dst));
    endtask

    task automatic run_multi(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int nstall);
        logic [29:0] e_pc;
        drive(op, a, b, 1'b0, 3'd0, 1'b0);
        e_pc = id_pc;
        for (int k = 0; k < 32; k++) begin
            #1;
            chk("mc_busy", 32'(ex_busy), 32'd1);
            if (k > 0) begin
                chk("mc_bub_en", 32'(ex_en_), 32'd1);
                chk("mc_bub_out", ex_out, 32'd0);
            end
            @(posedge clk); #1;
        end
        #1;
        chk("mc_last_busy", 32'(ex_busy), 32'd0);
        chk("mc_last_bub", 32'(ex_en_), 32'd1);
        if (nstall > 0) begin
            stall = 1'b1;
            for (int s = 0; s < nstall; s++) begin
                @(posedge clk); #1;
                chk("mc_hold_en", 32'(ex_en_), 32'd1);
                chk("mc_hold_busy", 32'(ex_busy), 32'd0);
            end
            stall = 1'b0;
        end
        @(posedge clk); #1;
        chk("mc_out", ex_out, ref_mc(op, a, b));
        chk("mc_en", 32'(ex_en_), 32'd0);
        chk("mc_pc", 32'(ex_pc), 32'(e_pc));
        chk("mc_exp", 32'(ex_exp_code), 32'd0);
        chk("mc_we", 32'(ex_gpr_we_), 32'd0);
        drive(4'd0, 32'd0, 32'd0, 1'b1, 3'd0, 1'b1);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  op;
        logic        en_;
        logic [2:0]  ec;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 1'b1, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        chk("rst_busy", 32'(ex_busy), 32'd0);
        reset = 1'b0;

        single(4'd4, 32'h7FFF_FFFF, 32'd1, 1'b0, 3'd0, 1'b0);
        single(4'd5, 32'h7FFF_FFFF, 32'd1, 1'b0, 3'd0, 1'b0);
        single(4'd6, 32'h8000_0000, 32'd1, 1'b0, 3'd0, 1'b0);
        single(4'd4, 32'h7FFF_FFFF, 32'd1, 1'b0, 3'd2, 1'b0);
        single(4'd4, 32'h7FFF_FFFF, 32'd1, 1'b1, 3'd0, 1'b0);
        single(4'd9, 32'd1, 32'h21, 1'b0, 3'd0, 1'b0);
        single(4'd8, 32'h8000_0000, 32'd31, 1'b0, 3'd0, 1'b0);
        single(4'd10, 32'd3, 32'd4, 1'b1, 3'd0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op  = 4'($urandom_range(0, 15));
            en_ = (op == 4'd10 || op == 4'd11) ? 1'b1
                                                : 1'($urandom);
            ec  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            single(op, rnd_word(), rnd_word(), en_, ec, 1'($urandom));
        end

        run_multi(4'd10, 32'h0001_2345, 32'h0000_0100, 0);
        run_multi(4'd11, 32'd100, 32'd7, 0);
        run_multi(4'd11, 32'd5, 32'd0, 0);
        run_multi(4'd10, $urandom, $urandom, 3);
        for (int i = 0; i < 6; i++) begin
            run_multi(($urandom_range(0, 1) == 1) ? 4'd10 : 4'd11,
                      $urandom,
                      ($urandom_range(0, 4) == 0) ? 32'd0
                                                  : 32'($urandom_range(1, 70000)),
                      0);
        end

        // flush aborts a MUL at cnt 10
        drive(4'd10, 32'd1234, 32'd5678, 1'b0, 3'd0, 1'b0);
        repeat (11) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        chk("flush_busy", 32'(ex_busy), 32'd0);
        @(posedge clk); #1;
        check_reset("flush");
        flush = 1'b0;
        single(4'd5, 32'd2, 32'd3, 1'b0, 3'd0, 1'b0);

        // stall holds, flush beats stall
        stall = 1'b1;
        drive(4'd5, 32'd10, 32'd10, 1'b0, 3'd0, 1'b0);
        @(posedge clk); #1;
        chk("stall_out", ex_out, 32'd5);
        chk("stall_en", 32'(ex_en_), 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        check_reset("flush_stall");
        flush = 1'b0;
        stall = 1'b0;

        // reset mid-DIVU
        drive(4'd11, 32'd1000, 32'd3, 1'b0, 3'd0, 1'b0);
        repeat (15) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_mid");
        reset = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 1'b1, 3'd0, 1'b1);
        #1;
        chk("rst_mid_idle", 32'(ex_busy), 32'd0);
        @(posedge clk); #1;
        run_multi(4'd11, 32'd1000, 32'd3, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline, directly downstream of the ID/EX pipeline registers. Performs ALU operations on the decoded operands, including an iterative 32-cycle multiplier and unsigned divider. Detects signed overflow and registers the result plus the pass-through control fields into the EX/MEM pipeline registers. While a multi-cycle operation runs, it requests a pipeline stall through `ex_busy`.

## Interface
- No parameters. Widths are fixed: word data 32, PC word address 30, ALU op 4, mem op 2, ctrl op 2, reg addr 5, exception code 3.
- Reset and clock (already decided): `reset` is synchronous and active-high; the clock is `clk`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hold the EX/MEM registers (from the pipeline controller).
- `flush` in 1: load a bubble and abort any multi-cycle operation.
- `id_pc` in 30: PC of the instruction.
- `id_en_` in 1: instruction valid, active-low.
- `id_alu_op` in 4: ALU operation. Encodings: NOP 0, AND 1, OR 2, XOR 3, ADDS 4, ADDU 5, SUBS 6, SUBU 7, SHRL 8, SHLL 9, MUL 10, DIVU 11. Codes 12–15 behave as NOP.
- `id_alu_in_0`, `id_alu_in_1` in 32 each: operands.
- `id_br_flag` in 1: branch-taken flag, passed through.
- `id_mem_op` in 2: memory operation; NOP is 0.
- `id_mem_wr_data` in 32: store data.
- `id_ctrl_op` in 2: control operation; NOP is 0.
- `id_dst_addr` in 5: destination register.
- `id_gpr_we_` in 1: register write enable, active-low.
- `id_exp_code` in 3: exception code. NO_EXP is 0, OVERFLOW is 3.
- `ex_busy` out 1: combinational stall request to the controller.
- `ex_fwd_data` out 32: combinational single-cycle ALU result, used for forwarding.
- `ex_pc` out 30; `ex_en_` out 1; `ex_br_flag` out 1; `ex_mem_op` out 2; `ex_mem_wr_data` out 32; `ex_ctrl_op` out 2; `ex_dst_addr` out 5; `ex_gpr_we_` out 1; `ex_exp_code` out 3; `ex_out` out 32: EX/MEM pipeline registers.

## Operation
- **Single-cycle ops.**
  - AND, OR, XOR: bitwise.
  - ADDS, ADDU: 32-bit add, wrapping.
  - SUBS, SUBU: `in_0 - in_1`, wrapping.
  - SHRL, SHLL: logical shift of `in_0` by `in_1[4:0]`.
  - NOP: result 0.
- **Signed overflow (ADDS/SUBS only), for a valid instruction.**
  - Applies when `id_exp_code` is NO_EXP.
  - `ex_exp_code` becomes OVERFLOW (3).
  - `ex_gpr_we_` is forced to 1 and `ex_mem_op` to NOP.
  - An incoming non-zero exception code takes priority and passes through unchanged.
- **Multi-cycle ops.**
  - MUL is shift-add over 32 iterations; the result is the low 32 bits of the product.
  - DIVU is restoring division over 32 iterations; the result is the quotient.
  - Divide by zero yields 32'hFFFFFFFF, which restoring division produces naturally. No exception is raised.
- **FSM states: IDLE and RUN, with a 5-bit iteration counter `cnt`.**
  - IDLE → RUN when `id_en_`=0, the op is MUL or DIVU, and `flush`=0. Operands are latched and `cnt` is set to 0.
  - In RUN, one iteration executes per cycle and `cnt` increments.
  - At `cnt`=31, the final iteration result is captured into `ex_out` (computed combinationally on that edge), and the FSM returns to IDLE.
  - The RUN completion edge is gated by `stall`: if `stall`=1 at `cnt`=31, the FSM stays in RUN with `cnt` held and `ex_busy`=0. Capture happens on the first non-stalled edge.
  - `flush` in any state returns the FSM to IDLE and discards the partial result.
- **`ex_busy`** is 1 in either of two cases:
  - state IDLE with a valid MUL/DIVU presented and `flush`=0;
  - state RUN with `cnt`≠31.
- **EX/MEM register update priority:** reset > flush > stall > busy > load.
  - reset and flush: every output is set to its reset value.
  - stall: all outputs hold.
  - busy: a bubble is loaded (reset values).
  - load: inputs are captured, with `ex_out` taking the ALU or multi-cycle result.
- **Reset values:** `ex_pc` 0, `ex_en_` 1, `ex_br_flag` 0, `ex_mem_op` 0, `ex_mem_wr_data` 0, `ex_ctrl_op` 0, `ex_dst_addr` 0, `ex_gpr_we_` 1, `ex_exp_code` 0, `ex_out` 0. The FSM resets to IDLE with `cnt`=0.
- **Invalid instructions** (`id_en_`=1) load normally. They never start the FSM and never raise overflow.

## Timing
- **Single-cycle op latency:** presented in cycle T, result visible on the EX/MEM outputs in T+1. `ex_fwd_data` is valid within cycle T.
- **MUL/DIVU latency:** presented in cycle T with `stall`=0 throughout.
  - `ex_busy` is 1 during cycles T..T+31 and 0 in T+32.
  - Upstream holds the `id_*` inputs while `ex_busy`=1.
  - The result and control fields appear in T+33.
  - EX/MEM outputs carry bubbles during T+1..T+32.
- **Back-to-back MUL:** the second MUL enters IDLE detection in T+33 and completes in T+66.
- **Reset mid-RUN:** the FSM goes to IDLE and all outputs take reset values on the next edge.
- **Simultaneous flush and stall:** flush wins.

## Test plan
- **Overflow:** ADDS 32'h7FFFFFFF + 1 with `id_gpr_we_`=0 and NO_EXP → next cycle `ex_out`=32'h80000000, `ex_exp_code`=3, `ex_gpr_we_`=1. The same operands with ADDU → `ex_exp_code`=0, `ex_gpr_we_`=0.
- **Multiply:** MUL 32'h00012345 × 32'h00000100 → `ex_busy` high for exactly 32 cycles, bubbles on the outputs, then `ex_out`=32'h01234500 in T+33.
- **Divide:** DIVU 100 / 7 → `ex_out`=14. DIVU 5 / 0 → `ex_out`=32'hFFFFFFFF with `ex_exp_code`=0.
- **Flush abort:** flush at `cnt`=10 during MUL → `ex_busy` falls the same cycle, outputs go to reset values next cycle, and a following ADDU 2+3 yields 5 one cycle later.
- **Stall and reset:**
  - Assert `stall` across the MUL completion cycle → outputs hold, and the result appears in the cycle after `stall` drops.
  - Assert `reset` mid-DIVU → all outputs take reset values and the FSM returns to IDLE.
- **Shifts:** SHLL 32'h1 by 32'h21 → `ex_out`=2 (only `in_1[4:0]` is used). SHRL 32'h80000000 by 31 → `ex_out`=1.
